// File: rtl/addsub_arbiter_8bit.sv
// Two-requester front end sharing one 8-bit adder/subtractor.
// Operands are latched on grant; results are held until consumed.
module adder_subtractor_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       op,
    output logic [7:0] sum,
    output logic       cout
);
    logic [8:0] total;

    // Subtract as a + ~b + 1 so cout reads as "no borrow".
    assign total = {1'b0, a} + {1'b0, b ^ {8{op}}} + {8'd0, op};
    assign sum   = total[7:0];
    assign cout  = total[8];
endmodule

module addsub_arbiter_8bit #(
    parameter bit FAIR = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic       req1_op,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_sum,
    output logic       rsp_cout,
    output logic       rsp_ovf,
    output logic       busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state, nstate;
    logic       last_q;
    logic       gnt_vld, gnt_id, accept;
    logic [7:0] a_q, b_q;
    logic       op_q, id_q;
    logic [7:0] sum_q;
    logic       cout_q, ovf_q;
    logic [7:0] dp_sum;
    logic       dp_cout, dp_ovf;

    adder_subtractor_8bit u_dp (
        .a    (a_q),
        .b    (b_q),
        .op   (op_q),
        .sum  (dp_sum),
        .cout (dp_cout)
    );

    assign dp_ovf = (op_q ? (a_q[7] != b_q[7]) : (a_q[7] == b_q[7]))
                    && (dp_sum[7] != a_q[7]);

    always_comb begin
        gnt_vld = req0_valid | req1_valid;
        gnt_id  = 1'b0;
        if (req0_valid && req1_valid)
            gnt_id = FAIR ? ~last_q : 1'b0;
        else
            gnt_id = req1_valid;
    end

    assign accept     = (state == IDLE) && gnt_vld;
    assign req0_ready = accept && !gnt_id;
    assign req1_ready = accept && gnt_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (accept) nstate = EXEC;
            EXEC:    nstate = RESP;
            RESP:    if (rsp_ready) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= 8'h00;
            b_q    <= 8'h00;
            op_q   <= 1'b0;
            id_q   <= 1'b0;
            sum_q  <= 8'h00;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            last_q <= 1'b1;
        end else begin
            if (accept) begin
                a_q  <= gnt_id ? req1_a  : req0_a;
                b_q  <= gnt_id ? req1_b  : req0_b;
                op_q <= gnt_id ? req1_op : req0_op;
                id_q <= gnt_id;
            end
            if (state == EXEC) begin
                sum_q  <= dp_sum;
                cout_q <= dp_cout;
                ovf_q  <= dp_ovf;
            end
            if (state == RESP && rsp_ready)
                last_q <= id_q;
        end
    end

    assign rsp_id   = id_q;
    assign rsp_sum  = sum_q;
    assign rsp_cout = cout_q;
    assign rsp_ovf  = ovf_q;
endmodule

// File: tb/tb_addsub_arbiter_8bit.sv
// Scoreboard bench: stimulus pushes expected results, monitors pop them.
// A second instance with fixed priority covers the FAIR=0 case.
module tb_addsub_arbiter_8bit;
    typedef struct packed {
        logic       id;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       r0v = 1'b0, r1v = 1'b0, fv0 = 1'b0, fv1 = 1'b0;
    logic       r0rdy, r1rdy, f0rdy, f1rdy;
    logic [7:0] r0a = 8'h00, r0b = 8'h00, r1a = 8'h00, r1b = 8'h00;
    logic       r0op = 1'b0, r1op = 1'b0;
    logic       rsp_ready = 1'b1;
    logic       rsp_valid, rsp_id, rsp_cout, rsp_ovf, busy;
    logic [7:0] rsp_sum;
    logic       f_valid, f_id, f_cout, f_ovf, f_busy;
    logic [7:0] f_sum;

    exp_t q[$];
    exp_t fq[$];
    int checks = 0;
    int errors = 0;
    int rsp_count = 0;

    always #5 clk = ~clk;

    addsub_arbiter_8bit #(.FAIR(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req0_ready(r0rdy),
        .req0_a(r0a), .req0_b(r0b), .req0_op(r0op),
        .req1_valid(r1v), .req1_ready(r1rdy),
        .req1_a(r1a), .req1_b(r1b), .req1_op(r1op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .busy(busy)
    );

    addsub_arbiter_8bit #(.FAIR(1'b0)) u_fp (
        .clk(clk), .rst(rst),
        .req0_valid(fv0), .req0_ready(f0rdy),
        .req0_a(r0a), .req0_b(r0b), .req0_op(r0op),
        .req1_valid(fv1), .req1_ready(f1rdy),
        .req1_a(r1a), .req1_b(r1b), .req1_op(r1op),
        .rsp_valid(f_valid), .rsp_ready(rsp_ready),
        .rsp_id(f_id), .rsp_sum(f_sum),
        .rsp_cout(f_cout), .rsp_ovf(f_ovf), .busy(f_busy)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic rsp_cmp(input string name, input exp_t e,
                           input logic id, input logic [7:0] s,
                           input logic c, input logic o);
        checks++;
        if ({id, s, c, o} !== e) begin
            errors++;
            $display("FAIL %s actual id=%0d sum=%02h cout=%0d ovf=%0d required id=%0d sum=%02h cout=%0d ovf=%0d",
                     name, id, s, c, o, e.id, e.sum, e.cout, e.ovf);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            rsp_count++;
            if (q.size() == 0) begin
                chk("unexpected_rsp", {31'd0, rsp_id}, 32'hFFFF);
            end else begin
                rsp_cmp("rsp", q.pop_front(), rsp_id, rsp_sum,
                        rsp_cout, rsp_ovf);
            end
        end
    end

    always @(negedge clk) begin
        if (f_valid && rsp_ready) begin
            if (fq.size() == 0)
                chk("fp_unexpected_rsp", {31'd0, f_id}, 32'hFFFF);
            else
                rsp_cmp("fp_rsp", fq.pop_front(), f_id, f_sum,
                        f_cout, f_ovf);
        end
    end

    task automatic wait_idle(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy && !f_busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, ok}, 32'd1);
    endtask

    // Issue one op and check the EXEC/RESP latency; returns in IDLE or RESP.
    task automatic do_op(input logic who, input logic [7:0] a, b,
                         input logic op, input logic [7:0] es,
                         input logic ec, eo);
        logic got;
        got = 1'b0;
        if (!who) begin
            r0a = a; r0b = b; r0op = op; r0v = 1'b1;
        end else begin
            r1a = a; r1b = b; r1op = op; r1v = 1'b1;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (who ? r1rdy : r0rdy) begin
                got = 1'b1;
                break;
            end
        end
        chk("accept", {31'd0, got}, 32'd1);
        if (got) q.push_back('{id: who, sum: es, cout: ec, ovf: eo});
        @(posedge clk); #1;
        r0v = 1'b0; r1v = 1'b0;
        if (!got) return;
        @(negedge clk);
        chk("exec_valid", {30'd0, busy, rsp_valid}, 32'd2);
        @(negedge clk);
        chk("resp_valid", {31'd0, rsp_valid}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, base;
        logic gid;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf,
                           busy, r0rdy, r1rdy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {30'd0, busy, rsp_valid}, 32'd0);
        @(posedge clk); #1;

        do_op(1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        do_op(1'b0, 8'h0F, 8'h01, 1'b1, 8'h0E, 1'b1, 1'b0);
        do_op(1'b0, 8'hF0, 8'h0F, 1'b1, 8'hE1, 1'b1, 1'b0);
        do_op(1'b0, 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0);
        do_op(1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        do_op(1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        do_op(1'b1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        do_op(1'b1, 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0);

        // Round-robin contention: last grant is 1, so 0 goes first.
        r0a = 8'h01; r0b = 8'h02; r0op = 1'b0;
        r1a = 8'h10; r1b = 8'h03; r1op = 1'b1;
        r0v = 1'b1; r1v = 1'b1;
        acc = 0;
        for (int i = 0; i < 40 && acc < 4; i++) begin
            @(negedge clk);
            if (r0rdy || r1rdy) begin
                gid = r1rdy;
                chk("rr_grant", {31'd0, gid}, acc % 2);
                if (acc % 2 == 0)
                    q.push_back('{id: 1'b0, sum: 8'h03, cout: 1'b0, ovf: 1'b0});
                else
                    q.push_back('{id: 1'b1, sum: 8'h0D, cout: 1'b1, ovf: 1'b0});
                acc++;
            end
        end
        chk("rr_count", acc, 4);
        @(posedge clk); #1;
        r0v = 1'b0; r1v = 1'b0;
        wait_idle("rr_drain");
        @(posedge clk); #1;

        // Fixed priority: requester 0 wins every tie.
        fv0 = 1'b1; fv1 = 1'b1;
        acc = 0;
        for (int i = 0; i < 40 && acc < 3; i++) begin
            @(negedge clk);
            if (f0rdy || f1rdy) begin
                chk("fp_grant", {31'd0, f1rdy}, 32'd0);
                fq.push_back('{id: 1'b0, sum: 8'h03, cout: 1'b0, ovf: 1'b0});
                acc++;
            end
        end
        chk("fp_count", acc, 3);
        @(posedge clk); #1;
        fv0 = 1'b0; fv1 = 1'b0;
        wait_idle("fp_drain");
        @(posedge clk); #1;

        // Backpressure: response held for 5 cycles with both valids up.
        base = rsp_count;
        rsp_ready = 1'b0;
        do_op(1'b0, 8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0);
        r0v = 1'b1; r1v = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold", {rsp_valid, rsp_id, rsp_sum, rsp_cout,
                            r0rdy, r1rdy}, {1'b1, 1'b0, 8'h77, 1'b0, 2'b00});
        end
        @(posedge clk); #1;
        r0v = 1'b0; r1v = 1'b0;
        rsp_ready = 1'b1;
        wait_idle("bp_drain");
        repeat (3) @(negedge clk);
        chk("bp_one_rsp", rsp_count - base, 1);
        @(posedge clk); #1;

        // Reset during EXEC discards the op and the pointer.
        base = rsp_count;
        r0a = 8'h0F; r0b = 8'h01; r0op = 1'b0; r0v = 1'b1;
        @(negedge clk);
        chk("rst_accept", {31'd0, r0rdy}, 32'd1);
        @(posedge clk); #1;
        r0v = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_async", {rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf,
                          busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_no_rsp", rsp_count - base, 0);
        @(posedge clk); #1;
        r1a = 8'h10; r1b = 8'h03; r1op = 1'b1;
        r0v = 1'b1; r1v = 1'b1;
        @(negedge clk);
        chk("rst_tie", {30'd0, r0rdy, r1rdy}, 32'd2);
        if (r0rdy)
            q.push_back('{id: 1'b0, sum: 8'h10, cout: 1'b0, ovf: 1'b0});
        @(posedge clk); #1;
        r0v = 1'b0; r1v = 1'b0;
        wait_idle("rst_drain");
        @(posedge clk); #1;

        // Request 1 pulses for one cycle during RESP and is withdrawn.
        base = rsp_count;
        rsp_ready = 1'b0;
        do_op(1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
        r1v = 1'b1;
        @(negedge clk);
        chk("wd_no_ready", {31'd0, r1rdy}, 32'd0);
        @(posedge clk); #1;
        r1v = 1'b0;
        rsp_ready = 1'b1;
        wait_idle("wd_drain");
        repeat (5) @(negedge clk);
        chk("wd_one_rsp", rsp_count - base, 1);
        chk("wd_idle", {31'd0, busy}, 32'd0);

        chk("queue_empty", q.size() + fq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
